adder_bist: RTL and testbench

//  Built-in self-test driver/checker for the 32-bit adder cores (CLA, ripple, etc.): drives a, b, cin into an adder

---
 rtl/adder_bist_pkg.sv | 65 ++++++
 rtl/adder_bist_if.sv | 25 ++
 rtl/adder_bist_lfsr.sv | 44 ++++
 rtl/adder_bist.sv | 206 ++++++++++++++++++++
 tb/tb_adder_bist.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST: FSM state encoding, the
// directed corner-vector table, the LFSR polynomial and the golden adder.
package adder_bist_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Galois feedback mask for x^32+x^22+x^2+x+1 (right-shifting form).
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam int          NUM_DIRECTED = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
  } vec_t;

  // Directed corner vectors: signed overflow both ways, carry-out,
  // carry-in, all-ones, and carry chains that stop short of the MSB.
  function automatic vec_t directed_vec(input logic [2:0] i);
    vec_t v;
    case (i)
      3'd0:    v = '{a: 32'h7fff_ffff, b: 32'h7fff_ffff, cin: 1'b0};
      3'd1:    v = '{a: 32'h8fff_ffff, b: 32'h8fff_ffff, cin: 1'b0};
      3'd2:    v = '{a: 32'h0000_07aa, b: 32'hffff_ffff, cin: 1'b0};
      3'd3:    v = '{a: 32'h0000_00af, b: 32'h0000_00af, cin: 1'b1};
      3'd4:    v = '{a: 32'hffff_ffff, b: 32'hffff_ffff, cin: 1'b0};
      3'd5:    v = '{a: 32'h0000_0123, b: 32'hffff_f123, cin: 1'b0};
      3'd6:    v = '{a: 32'hffff_f999, b: 32'h0000_0111, cin: 1'b0};
      default: v = '{a: 32'h0000_0000, b: 32'hffff_ffff, cin: 1'b0};
    endcase
    return v;
  endfunction

  // One Galois LFSR step: shift right, fold the polynomial in when a one
  // falls out of bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
  endfunction

  // Reference a+b+cin over the low w bits (1..32). Returns {cout, ovf, sum}
  // with sum zero-extended to 32 bits.
  function automatic logic [33:0] golden_add(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        cin,
                                             input logic [5:0]  w);
    logic [31:0] mask;
    logic [32:0] s;
    logic [5:0]  msb;
    logic        c;
    logic        o;
    mask = (w >= 6'd32) ? 32'hffff_ffff : ((32'h1 << w) - 32'h1);
    s    = {1'b0, a & mask} + {1'b0, b & mask} + {32'h0, cin};
    msb  = w - 6'd1;
    c    = s[w];
    o    = (a[msb[4:0]] == b[msb[4:0]]) && (s[msb] != a[msb[4:0]]);
    return {c, o, s[31:0] & mask};
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Bus between the BIST engine (master) and the adder under test (slave).
// Timing contract: the master changes add_a/add_b/add_cin only on its LOAD
// cycle and holds them for the whole settle window; the slave's add_sum,
// add_cout and add_of are sampled once, at the end of that window, so the
// adder may be purely combinational with any delay shorter than the window.
interface adder_bist_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_of;

  modport master (
    output add_a, add_b, add_cin,
    input  add_sum, add_cout, add_of
  );

  modport slave (
    input  add_a, add_b, add_cin,
    output add_sum, add_cout, add_of
  );
endinterface

// File: rtl/adder_bist_lfsr.sv
// 32-bit Galois LFSR for the random phase. Exposes the current value and its
// one-step successor so a single LOAD can draw two operands, then jumps two
// steps ahead so the next draw starts on fresh state.
module adder_bist_lfsr
  import adder_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv2_i,
  output logic [31:0] cur_o,
  output logic [31:0] nxt_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [31:0] step1;

  // Next-state: reload the seed, advance by two, or hold.
  always_comb begin
    step1  = lfsr_step(lfsr_q);
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (adv2_i) begin
      lfsr_d = lfsr_step(step1);
    end
  end

  // State register; reset puts the seed back so every run repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign cur_o = lfsr_q;
  assign nxt_o = step1;

endmodule

// File: rtl/adder_bist.sv
// Built-in self-test driver/checker for a WIDTH-bit adder. Drives 8 directed
// corner vectors then LFSR-random vectors, waits SETTLE_CYCLES per vector,
// and compares sum/cout/overflow against a golden model.
// Optional build macro ADDER_BIST_CAPTURE_EN adds cap_* outputs holding the
// operands and response of the first mismatching vector.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int          WIDTH         = 32,
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  adder_bist_if.master     bus,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      fail_cnt,
  output logic [15:0]      first_fail_idx
`ifdef ADDER_BIST_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] cap_a,
  output logic [WIDTH-1:0] cap_b,
  output logic             cap_cin,
  output logic [WIDTH-1:0] cap_sum,
  output logic             cap_cout,
  output logic             cap_of
`endif
);

  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DIR_LAST    = 16'(NUM_DIRECTED - 1);
  localparam logic [15:0] NO_FAIL     = 16'hffff;
  localparam logic [15:0] CNT_MAX     = 16'hffff;

  state_e           state_q;
  logic [15:0]      idx_q;
  logic [15:0]      settle_q;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_b_q;
  logic             add_cin_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      pass_q;
  logic [15:0]      fail_q;
  logic [15:0]      ffi_q;
`ifdef ADDER_BIST_CAPTURE_EN
  logic [WIDTH-1:0] cap_a_q;
  logic [WIDTH-1:0] cap_b_q;
  logic             cap_cin_q;
  logic [WIDTH-1:0] cap_sum_q;
  logic             cap_cout_q;
  logic             cap_of_q;
`endif

  logic        start_ok;
  logic        lfsr_adv;
  logic [31:0] lfsr_cur;
  logic [31:0] lfsr_nxt;
  vec_t        dir_v;
  logic [33:0] gold;
  logic        match;

  // start only counts when the engine is not running.
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign lfsr_adv = (state_q == LOAD) && (idx_q > DIR_LAST);
  assign dir_v    = directed_vec(idx_q[2:0]);

  adder_bist_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (start_ok),
    .adv2_i (lfsr_adv),
    .cur_o  (lfsr_cur),
    .nxt_o  (lfsr_nxt)
  );

  // Golden response for the operands currently on the bus.
  assign gold  = golden_add(32'(add_a_q), 32'(add_b_q), add_cin_q, 6'(WIDTH));
  assign match = (bus.add_sum  == gold[WIDTH-1:0]) &&
                 (bus.add_cout == gold[33]) &&
                 (bus.add_of   == gold[32]);

  // Run sequencer: IDLE/DONE wait for start, LOAD drives a vector, SETTLE
  // holds it, CHECK scores it and either loops or finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 16'h0;
      settle_q  <= 16'h0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 16'h0;
      fail_q    <= 16'h0;
      ffi_q     <= NO_FAIL;
`ifdef ADDER_BIST_CAPTURE_EN
      cap_a_q    <= '0;
      cap_b_q    <= '0;
      cap_cin_q  <= 1'b0;
      cap_sum_q  <= '0;
      cap_cout_q <= 1'b0;
      cap_of_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            idx_q   <= 16'h0;
            pass_q  <= 16'h0;
            fail_q  <= 16'h0;
            ffi_q   <= NO_FAIL;
`ifdef ADDER_BIST_CAPTURE_EN
            cap_a_q    <= '0;
            cap_b_q    <= '0;
            cap_cin_q  <= 1'b0;
            cap_sum_q  <= '0;
            cap_cout_q <= 1'b0;
            cap_of_q   <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (idx_q > DIR_LAST) begin
            add_a_q   <= lfsr_cur[WIDTH-1:0];
            add_b_q   <= lfsr_nxt[WIDTH-1:0];
            add_cin_q <= lfsr_nxt[31];
          end else begin
            add_a_q   <= dir_v.a[WIDTH-1:0];
            add_b_q   <= dir_v.b[WIDTH-1:0];
            add_cin_q <= dir_v.cin;
          end
          settle_q <= 16'h0;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= CHECK;
          end else begin
            settle_q <= settle_q + 16'h1;
          end
        end
        CHECK: begin
          if (match) begin
            if (pass_q != CNT_MAX) pass_q <= pass_q + 16'h1;
          end else begin
            if (fail_q != CNT_MAX) fail_q <= fail_q + 16'h1;
            if (ffi_q == NO_FAIL) begin
              ffi_q <= idx_q;
`ifdef ADDER_BIST_CAPTURE_EN
              cap_a_q    <= add_a_q;
              cap_b_q    <= add_b_q;
              cap_cin_q  <= add_cin_q;
              cap_sum_q  <= bus.add_sum;
              cap_cout_q <= bus.add_cout;
              cap_of_q   <= bus.add_of;
`endif
            end
          end
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 16'h1;
            state_q <= LOAD;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.add_cin    = add_cin_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
`ifdef ADDER_BIST_CAPTURE_EN
  assign cap_a          = cap_a_q;
  assign cap_b          = cap_b_q;
  assign cap_cin        = cap_cin_q;
  assign cap_sum        = cap_sum_q;
  assign cap_cout       = cap_cout_q;
  assign cap_of         = cap_of_q;
`endif

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: a 32-bit 8-vector instance around a behavioural
// adder with fault knobs, and a 16-bit 1000-vector instance around a clean
// adder. Operand sequences are checked against a scoreboard queue built from
// the directed table and an LFSR model; final counts against a scenario table.
module tb_adder_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, rst_b, start_b;
  logic k_cout0, k_of0, k_inv0;

  int checks   = 0;
  int failures = 0;
  logic [64:0] exp_q[$];

  logic [31:0] dir_a [8] = '{32'h7fffffff, 32'h8fffffff, 32'h000007aa, 32'h000000af,
                             32'hffffffff, 32'h00000123, 32'hfffff999, 32'h00000000};
  logic [31:0] dir_b [8] = '{32'h7fffffff, 32'h8fffffff, 32'hffffffff, 32'h000000af,
                             32'hffffffff, 32'hfffff123, 32'h00000111, 32'hffffffff};
  logic        dir_c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  adder_bist_if #(.WIDTH(32)) bus_a ();
  adder_bist_if #(.WIDTH(16)) bus_b ();

  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] pass_a, fail_a, ffi_a, pass_b, fail_b, ffi_b;
`ifdef ADDER_BIST_CAPTURE_EN
  logic [31:0] cap_a_a, cap_b_a, cap_sum_a;
  logic        cap_cin_a, cap_cout_a, cap_of_a;
  logic [15:0] cap_a_b, cap_b_b, cap_sum_b;
  logic        cap_cin_b, cap_cout_b, cap_of_b;
`endif

  adder_bist #(.WIDTH(32), .NUM_VECTORS(8), .SETTLE_CYCLES(2), .LFSR_SEED(32'hACE12468)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .pass_cnt(pass_a), .fail_cnt(fail_a), .first_fail_idx(ffi_a)
`ifdef ADDER_BIST_CAPTURE_EN
    , .cap_a(cap_a_a), .cap_b(cap_b_a), .cap_cin(cap_cin_a),
    .cap_sum(cap_sum_a), .cap_cout(cap_cout_a), .cap_of(cap_of_a)
`endif
  );

  adder_bist #(.WIDTH(16), .NUM_VECTORS(1000), .SETTLE_CYCLES(1), .LFSR_SEED(32'hACE12468)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .pass_cnt(pass_b), .fail_cnt(fail_b), .first_fail_idx(ffi_b)
`ifdef ADDER_BIST_CAPTURE_EN
    , .cap_a(cap_a_b), .cap_b(cap_b_b), .cap_cin(cap_cin_b),
    .cap_sum(cap_sum_b), .cap_cout(cap_cout_b), .cap_of(cap_of_b)
`endif
  );

  // Behavioural adders under test.
  logic [32:0] ref_a;
  logic [16:0] ref_b;
  assign ref_a = {1'b0, bus_a.add_a} + {1'b0, bus_a.add_b} + {32'h0, bus_a.add_cin};
  assign bus_a.add_sum  = ref_a[31:0] ^ {31'h0, k_inv0};
  assign bus_a.add_cout = k_cout0 ? 1'b0 : ref_a[32];
  assign bus_a.add_of   = k_of0 ? 1'b0 :
                          ((bus_a.add_a[31] == bus_a.add_b[31]) && (ref_a[31] != bus_a.add_a[31]));
  assign ref_b = {1'b0, bus_b.add_a} + {1'b0, bus_b.add_b} + {16'h0, bus_b.add_cin};
  assign bus_b.add_sum  = ref_b[15:0];
  assign bus_b.add_cout = ref_b[16];
  assign bus_b.add_of   = (bus_b.add_a[15] == bus_b.add_b[15]) && (ref_b[15] != bus_b.add_a[15]);

  typedef struct {
    logic        kc, ko, ki;
    int          pulse;
    logic [15:0] pass, fail, ffi;
    logic [31:0] ca, cb, cs;
    logic        cc, co;
  } sc_t;
  sc_t tbl [5];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  task automatic push_a_expect();
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back({dir_a[k], dir_b[k], dir_c[k]});
  endtask

  task automatic push_b_expect();
    logic [31:0] l, f1;
    exp_q.delete();
    l = 32'hACE12468;
    for (int k = 0; k < 1000; k++) begin
      if (k < 8) begin
        exp_q.push_back({16'h0, dir_a[k][15:0], 16'h0, dir_b[k][15:0], dir_c[k]});
      end else begin
        f1 = lstep(l);
        exp_q.push_back({16'h0, l[15:0], 16'h0, f1[15:0], f1[31]});
        l = lstep(f1);
      end
    end
  endtask

  // Start dut_a, score every LOAD, optionally pulse start mid-run at t=pulse_at.
  task automatic run_a(input int pulse_at, output int done_at);
    int t;
    logic [64:0] e;
    push_a_expect();
    done_at = -1;
    t = 0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    while (done_at < 0 && t < 100) begin
      if (t == pulse_at) start_a = 1'b1;
      @(posedge clk); t++;
      @(negedge clk); start_a = 1'b0;
      if ((t % 4) == 1 && t < 32) begin
        if (exp_q.size() == 0) chk("a_sb_underflow", 65'd1, 65'd0);
        else begin
          e = exp_q.pop_front();
          chk("a_operands", {bus_a.add_a, bus_a.add_b, bus_a.add_cin}, e);
        end
        if (t == 1) chk("a_busy_run", 65'(busy_a), 65'd1);
      end
      if (done_a) done_at = t;
    end
    chk("a_done_latency", 65'(done_at), 65'd32);
    chk("a_busy_after", 65'(busy_a), 65'd0);
    chk("a_sb_drained", 65'(exp_q.size()), 65'd0);
  endtask

  task automatic run_b();
    int t, done_at;
    logic [64:0] e;
    push_b_expect();
    done_at = -1;
    t = 0;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    @(negedge clk); start_b = 1'b0;
    while (done_at < 0 && t < 3100) begin
      @(posedge clk); t++;
      @(negedge clk);
      if ((t % 3) == 1 && t < 3000) begin
        if (exp_q.size() == 0) chk("b_sb_underflow", 65'd1, 65'd0);
        else begin
          e = exp_q.pop_front();
          chk("b_operands", {16'h0, bus_b.add_a, 16'h0, bus_b.add_b, bus_b.add_cin}, e);
        end
      end
      if (done_b) done_at = t;
    end
    chk("b_done_latency", 65'(done_at), 65'd3000);
    chk("b_pass", 65'(pass_b), 65'd1000);
    chk("b_fail", 65'(fail_b), 65'd0);
    chk("b_ffi", 65'(ffi_b), 65'hffff);
    chk("b_sb_drained", 65'(exp_q.size()), 65'd0);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_add_a"}, 65'(bus_a.add_a), 65'd0);
    chk({tag, "_add_b"}, 65'(bus_a.add_b), 65'd0);
    chk({tag, "_cin"},   65'(bus_a.add_cin), 65'd0);
    chk({tag, "_busy"},  65'(busy_a), 65'd0);
    chk({tag, "_done"},  65'(done_a), 65'd0);
    chk({tag, "_pass"},  65'(pass_a), 65'd0);
    chk({tag, "_fail"},  65'(fail_a), 65'd0);
    chk({tag, "_ffi"},   65'(ffi_a), 65'hffff);
`ifdef ADDER_BIST_CAPTURE_EN
    chk({tag, "_cap_a"}, 65'(cap_a_a), 65'd0);
`endif
  endtask

  initial begin
    int done_at;
    tbl[0] = '{kc:0, ko:0, ki:0, pulse:-1, pass:8, fail:0, ffi:16'hffff,
               ca:0, cb:0, cs:0, cc:0, co:0};
    tbl[1] = '{kc:1, ko:0, ki:0, pulse:-1, pass:5, fail:3, ffi:16'd1,
               ca:32'h8fffffff, cb:32'h8fffffff, cs:32'h1ffffffe, cc:0, co:1};
    tbl[2] = '{kc:0, ko:1, ki:0, pulse:10, pass:6, fail:2, ffi:16'd0,
               ca:32'h7fffffff, cb:32'h7fffffff, cs:32'hfffffffe, cc:0, co:0};
    tbl[3] = '{kc:0, ko:0, ki:1, pulse:-1, pass:0, fail:8, ffi:16'd0,
               ca:32'h7fffffff, cb:32'h7fffffff, cs:32'hffffffff, cc:0, co:1};
    tbl[4] = '{kc:1, ko:1, ki:0, pulse:20, pass:4, fail:4, ffi:16'd0,
               ca:32'h7fffffff, cb:32'h7fffffff, cs:32'hfffffffe, cc:0, co:0};

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    k_cout0 = 1'b0; k_of0 = 1'b0; k_inv0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_a("rst0");
    chk("rst0_b_done", 65'(done_b), 65'd0);
    chk("rst0_b_ffi", 65'(ffi_b), 65'hffff);
    rst_a = 1'b0; rst_b = 1'b0;

    // Scenario table on the 8-vector instance.
    for (int i = 0; i < 5; i++) begin
      k_cout0 = tbl[i].kc; k_of0 = tbl[i].ko; k_inv0 = tbl[i].ki;
      run_a(tbl[i].pulse, done_at);
      chk("a_pass", 65'(pass_a), 65'(tbl[i].pass));
      chk("a_fail", 65'(fail_a), 65'(tbl[i].fail));
      chk("a_ffi",  65'(ffi_a),  65'(tbl[i].ffi));
      chk("a_done_held", 65'(done_a), 65'd1);
`ifdef ADDER_BIST_CAPTURE_EN
      chk("a_cap_a",    65'(cap_a_a),    65'(tbl[i].ca));
      chk("a_cap_b",    65'(cap_b_a),    65'(tbl[i].cb));
      chk("a_cap_cin",  65'(cap_cin_a),  65'd0);
      chk("a_cap_sum",  65'(cap_sum_a),  65'(tbl[i].cs));
      chk("a_cap_cout", 65'(cap_cout_a), 65'(tbl[i].cc));
      chk("a_cap_of",   65'(cap_of_a),   65'(tbl[i].co));
`endif
    end

    // Reset in the middle of a run (vector 5 just loaded), then rerun.
    k_cout0 = 1'b1; k_of0 = 1'b0; k_inv0 = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    chk("mid_operands", {bus_a.add_a, bus_a.add_b, bus_a.add_cin}, {32'h123, 32'hfffff123, 1'b0});
    chk("mid_pass", 65'(pass_a), 65'd2);
    chk("mid_fail", 65'(fail_a), 65'd3);
    chk("mid_ffi",  65'(ffi_a),  65'd1);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    chk_reset_a("rst1");
    run_a(-1, done_at);
    chk("rerun_pass", 65'(pass_a), 65'd5);
    chk("rerun_fail", 65'(fail_a), 65'd3);
    chk("rerun_ffi",  65'(ffi_a),  65'd1);

    // Long random run on the 16-bit instance, twice to show the LFSR repeats.
    run_b();
    run_b();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
